apb4_cmd_master: RTL and testbench
==================================

Name: apb4_cmd_master

Overview:
- Synthesizable APB4 requester: accepts read/write commands on a valid/ready request channel and buffers them in a CMD_DEPTH FIFO.
- Executes them as APB4 SETUP/ACCESS transfers with wait-state support.
- Returns read data and error status on a valid/ready response channel.
- Used as the bus-side master in regblock integration benches and as a reusable CPU-bridge leaf.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8.
- ADDR_WIDTH, 32, PADDR width.
- CMD_DEPTH, 4, request FIFO entries; power of two, >=2.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  FIFO not full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- req_prot  in  3  PPROT value.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR (or timeout) of the transfer.
- timeout_seen  out  1  sticky timeout flag.
- PSEL  out  1.
- PENABLE  out  1.
- PWRITE  out  1.
- PADDR  out  ADDR_WIDTH.
- PWDATA  out  DATA_WIDTH.
- PSTRB  out  DATA_WIDTH/8.
- PPROT  out  3.
- PRDATA  in  DATA_WIDTH.
- PREADY  in  1.
- PSLVERR  in  1.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO and response buffer emptied; FSM to IDLE. Reset mid-transfer abandons the transfer silently; no response is produced.
- Request FIFO:
  - Push on req_valid && req_ready.
  - req_ready = !full; remains combinationally valid while full if a pop occurs the same cycle.
  - Simultaneous push/pop when full is permitted.
  - Pointers wrap modulo CMD_DEPTH.
- Response buffer: 2 entries, in-order.
  - rsp_valid = nonempty; pop on rsp_valid && rsp_ready.
  - rsp_rdata/rsp_err held stable while rsp_valid && !rsp_ready.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when FIFO nonempty and response-buffer occupancy after this cycle's pop is <=1. The head entry is popped and registered onto the APB outputs.
  - SETUP: PSEL=1, PENABLE=0; unconditionally -> ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0.
  - ACCESS completion (PREADY=1): capture rsp_rdata = write ? 0 : PRDATA and rsp_err = PSLVERR; push into response buffer. Next state is SETUP if the IDLE->SETUP condition holds (back-to-back, no idle cycle), else IDLE.
- APB output values:
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT are constant from SETUP through completion.
  - Reads drive PSTRB=0 and PWDATA=0.
  - In IDLE, PSEL=PENABLE=0 and all other APB outputs are driven to 0.
- Throughput: 2 cycles per zero-wait transfer when the consumer keeps rsp_ready=1.
- Latency: request accept to PSEL = 1 cycle from an empty FIFO in IDLE. ACCESS completion to rsp_valid = 1 cycle.
- Backpressure: holding rsp_ready=0 stops new transfers after two responses are buffered. An in-flight transfer always has buffer space.
- PRDATA/PSLVERR are sampled only in the completion cycle.

Optional Feature:
- Macro: APB4_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A counter resets on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYCLES, the transfer is terminated: PSEL/PENABLE drop next cycle, and a response is pushed with rsp_err=1, rsp_rdata=0.
  - timeout_seen sets and holds until rst.
  - A PREADY=1 arriving on the same cycle the limit is reached wins; it is a normal completion.
- When undefined: no counter; ACCESS waits indefinitely; timeout_seen tied 0.

Test Plan:
- Write 0x10 data 0xDEADBEEF strb 0xF prot 0x2, PREADY=1 immediately -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later; PSTRB=0xF, PPROT=2; response rsp_err=0, rsp_rdata=0.
- Read 0x20 with PREADY low 3 cycles, PRDATA=0x1234, PSLVERR=1 -> ACCESS lasts 4 cycles; PSTRB=0, PWDATA=0; response rdata 0x1234, err=1.
- Push 6 reads with CMD_DEPTH=4 and rsp_ready=1 -> req_ready drops at 4 queued; transfers run back-to-back at 2 cycles each; 6 in-order responses.
- rsp_ready=0 with 4 queued commands -> exactly 2 transfers complete then PSEL stays 0; raising rsp_ready resumes and all 4 responses return in order.
- Assert rst during ACCESS -> all outputs 0 asynchronously; after release no response appears and req_ready=1.
- With TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY held 0 -> PSEL drops after 8 ACCESS cycles; response err=1, data=0; timeout_seen=1.

Source files
------------

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master: APB4 requester with a command FIFO, SETUP/ACCESS sequencing and a 2-entry response buffer.
// Define APB4_CMD_MASTER_TIMEOUT_EN to terminate ACCESS phases that exceed TIMEOUT_CYCLES.
module apb4_cmd_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    timeout_seen,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = ADDR_WIDTH + DATA_WIDTH + SW + 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (DATA_WIDTH % 8 != 0 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb4_cmd_master: illegal parameter value");
    end

    logic [CW-1:0]         fifo_mem [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] rb_data [2];
    logic [1:0]            rb_err;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    logic                  rb_wr_q, rb_wr_d, rb_rd_q, rb_rd_d;
    logic [1:0]            rb_cnt_q, rb_cnt_d, occ_next;
    state_t                state_q, state_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rb_wdata;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [CW-1:0]         head;
    logic                  push, pop, rsp_pop, rb_push, rb_werr, start, tmo;

    assign head      = fifo_mem[rd_ptr_q];
    assign rsp_valid = rb_cnt_q != 2'd0;
    assign rsp_rdata = rsp_valid ? rb_data[rb_rd_q] : '0;
    assign rsp_err   = rsp_valid && rb_err[rb_rd_q];
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rb_push   = state_q == ACCESS && (PREADY || tmo);
    // Counting the push of the completing transfer keeps a slot free for whatever starts next.
    assign occ_next  = rb_cnt_q - 2'(rsp_pop) + 2'(rb_push);
    assign start     = cnt_q != '0 && occ_next <= 2'd1;
    assign pop       = start && (state_q == IDLE || rb_push);
    assign req_ready = !rst && (cnt_q != (PW+1)'(CMD_DEPTH) || pop);
    assign push      = req_valid && req_ready;
    assign rb_wdata  = (pwrite_q || !PREADY) ? '0 : PRDATA;
    assign rb_werr   = PREADY ? PSLVERR : 1'b1;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
    assign PPROT   = pprot_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        rb_wr_d   = rb_wr_q ^ rb_push;
        rb_rd_d   = rb_rd_q ^ rsp_pop;
        rb_cnt_d  = occ_next;
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        if (pop) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head[CW-1];
            pprot_d   = head[CW-2 -: 3];
            pstrb_d   = head[CW-1] ? head[ADDR_WIDTH+DATA_WIDTH +: SW] : '0;
            pwdata_d  = head[CW-1] ? head[ADDR_WIDTH +: DATA_WIDTH] : '0;
            paddr_d   = head[ADDR_WIDTH-1:0];
        end else if (state_q == SETUP) begin
            state_d   = ACCESS;
            penable_d = 1'b1;
        end else if (rb_push) begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            paddr_d   = '0;
            pwdata_d  = '0;
            pstrb_d   = '0;
            pprot_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {req_write, req_prot, req_strb, req_wdata, req_addr};
        if (rb_push) begin
            rb_data[rb_wr_q] <= rb_wdata;
            rb_err[rb_wr_q]  <= rb_werr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rb_wr_q   <= 1'b0;
            rb_rd_q   <= 1'b0;
            rb_cnt_q  <= '0;
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rb_wr_q   <= rb_wr_d;
            rb_rd_q   <= rb_rd_d;
            rb_cnt_q  <= rb_cnt_d;
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
        end
    end

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_seen_q, timeout_seen_d;

    // A PREADY arriving on the limit cycle is a normal completion, hence the !PREADY term.
    assign tmo          = state_q == ACCESS && !PREADY && to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign timeout_seen = timeout_seen_q;

    always_comb begin
        to_cnt_d       = state_q == SETUP ? '0 : (state_q == ACCESS && !PREADY) ? to_cnt_q + 1'b1 : to_cnt_q;
        timeout_seen_d = timeout_seen_q || tmo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q       <= '0;
            timeout_seen_q <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end
`else
    assign tmo          = 1'b0;
    assign timeout_seen = 1'b0;
`endif
endmodule

// File: tb/tb_apb4_cmd_master.sv
// tb_apb4_cmd_master: directed self-checking bench for apb4_cmd_master.
// Timeout steps run only when APB4_CMD_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8 here).
module tb_apb4_cmd_master;
    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_err, timeout_seen;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA, prdata_v;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        prd_fixed;
    int          total = 0, passed = 0;
    int          n, got, last, cyc, ncomp;

    // Mapped mode returns a read value derived from the address so ordering is observable.
    assign PRDATA = prd_fixed ? prdata_v : (32'hA5A5_0000 | PADDR);

    always #5 clk = ~clk;

    apb4_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .timeout_seen(timeout_seen),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic wr, input logic [31:0] addr);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0; req_prot = 0;
        rsp_ready = 0; PREADY = 0; PSLVERR = 0; prd_fixed = 1; prdata_v = 0;
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_paddr", PADDR, 0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("rel_req_ready", req_ready, 1);

        // Zero-wait write
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_strb = 4'hF; req_prot = 3'd2;
        PREADY = 1;
        #1 chk("w_ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("w_psel_idle", PSEL, 0);
        step();
        chk("w_setup_psel", PSEL, 1);
        chk("w_setup_pen", PENABLE, 0);
        chk("w_paddr", PADDR, 32'h10);
        chk("w_pwdata", PWDATA, 32'hDEADBEEF);
        chk("w_pstrb", PSTRB, 4'hF);
        chk("w_pprot", PPROT, 3'd2);
        chk("w_pwrite", PWRITE, 1);
        step();
        chk("w_access_pen", PENABLE, 1);
        chk("w_access_pstrb", PSTRB, 4'hF);
        step();
        chk("w_done_psel", PSEL, 0);
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_rdata", rsp_rdata, 0);
        chk("w_rsp_err", rsp_err, 0);
        rsp_ready = 1;
        step();
        chk("w_rsp_popped", rsp_valid, 0);
        rsp_ready = 0;

        // Read with 3 wait states and slave error
        prdata_v = 32'h1234; PSLVERR = 1; PREADY = 0; req_wdata = 32'hFFFF_FFFF;
        send(0, 32'h20);
        step();
        chk("r_pstrb", PSTRB, 0);
        chk("r_pwdata", PWDATA, 0);
        chk("r_pwrite", PWRITE, 0);
        chk("r_paddr", PADDR, 32'h20);
        step();
        n = 0;
        while (PENABLE && n < 20) begin
            PREADY = (n == 3);
            step();
            n++;
        end
        chk("r_access_len", n, 4);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_rdata", rsp_rdata, 32'h1234);
        chk("r_rsp_err", rsp_err, 1);
        prdata_v = 32'h9999;
        step();
        chk("r_rsp_hold", rsp_rdata, 32'h1234);
        chk("r_rsp_hold_err", rsp_err, 1);
        PSLVERR = 0; rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Six reads: fill FIFO behind a stalled transfer, then stream back-to-back
        prd_fixed = 0; rsp_ready = 1; PREADY = 0; req_write = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1; req_addr = 32'h100 + 32'(4 * i);
            step();
        end
        req_addr = 32'h114;
        #1 chk("f_full_ready", req_ready, 0);
        PREADY = 1;
        #1 chk("f_full_pop_ready", req_ready, 1);
        step();
        req_valid = 0;
        got = 0; cyc = 0; last = 0;
        while (got < 6 && cyc < 40) begin
            if (rsp_valid) begin
                chk("f_rdata", rsp_rdata, 32'hA5A5_0100 + 32'(4 * got));
                if (got > 0) chk("f_gap", cyc - last, 2);
                last = cyc;
                got++;
            end
            step();
            cyc++;
        end
        chk("f_count", got, 6);

        // Backpressure: only two transfers may complete while rsp_ready is low
        rsp_ready = 0; PREADY = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = 32'h200 + 32'(4 * i);
            step();
        end
        req_valid = 0; PREADY = 1; ncomp = 0;
        repeat (12) begin
            if (PSEL && PENABLE && PREADY) ncomp++;
            step();
        end
        chk("b_completions", ncomp, 2);
        chk("b_psel_idle", PSEL, 0);
        chk("b_rsp_head", rsp_rdata, 32'hA5A5_0200);
        rsp_ready = 1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            if (rsp_valid) begin
                chk("b_rdata", rsp_rdata, 32'hA5A5_0200 + 32'(4 * got));
                got++;
            end
            step();
            cyc++;
        end
        chk("b_count", got, 4);
        rsp_ready = 0;

        // Reset in the middle of ACCESS
        PREADY = 0;
        send(0, 32'h300);
        step();
        step();
        chk("x_in_access", PENABLE, 1);
        #2 rst = 1'b1;
        #1;
        chk("x_psel", PSEL, 0);
        chk("x_penable", PENABLE, 0);
        chk("x_paddr", PADDR, 0);
        chk("x_req_ready", req_ready, 0);
        @(negedge clk) rst = 1'b0;
        PREADY = 1;
        repeat (3) step();
        chk("x_no_rsp", rsp_valid, 0);
        chk("x_psel_after", PSEL, 0);
        chk("x_ready_after", req_ready, 1);

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
        PREADY = 0;
        send(1, 32'h400);
        step();
        step();
        n = 0;
        while (PSEL && n < 40) begin
            step();
            n++;
        end
        chk("t_access_len", n, 8);
        chk("t_rsp_err", rsp_err, 1);
        chk("t_rsp_rdata", rsp_rdata, 0);
        chk("t_seen", timeout_seen, 1);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        send(0, 32'h404);
        step();
        step();
        n = 0;
        while (PSEL && n < 40) begin
            PREADY = (n == 7);
            step();
            n++;
        end
        PREADY = 0;
        chk("t_edge_len", n, 8);
        chk("t_edge_err", rsp_err, 0);
        chk("t_edge_rdata", rsp_rdata, 32'hA5A5_0404);
        chk("t_seen_sticky", timeout_seen, 1);
`else
        chk("t_seen_tied", timeout_seen, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
